// File: rtl/crash_detector.sv
// ---------------------------------------------------------------------------
// crash_detector
//
// Purpose:
//   Decides once per video frame whether the player sprite has left the road.
//   A crash is declared after DEBOUNCE_FRAMES consecutive off-road frames.
//   When a crash is declared, `dead` is held high for DEAD_FRAMES frames so
//   that a synchronizer in any clock domain reliably catches it. After that
//   the block either returns to ALIVE or passes through an invincibility
//   window of GRACE_FRAMES frames. A saturating 8-bit crash counter is kept.
//
// Configuration macro:
//   CRASH_GRACE_EN - when defined, the GRACE state exists. When undefined,
//                    DEAD returns straight to ALIVE and `state` is never 2.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   frame_tick   in   one-cycle pulse per frame; geometry is sampled only here
//   player_x     in   player sprite left edge
//   road_left    in   road left edge (inclusive)
//   road_right   in   road right edge (inclusive)
//   dead         out  registered, high while in DEAD
//   offroad      out  registered off-road result of the latest sampled frame
//   state        out  registered state: 0=ALIVE, 1=DEAD, 2=GRACE
//   crash_count  out  registered crash count, saturates at 255
// ---------------------------------------------------------------------------
module crash_detector #(
    parameter int COORD_W         = 10,
    parameter int PLAYER_W        = 16,
    parameter int DEBOUNCE_FRAMES = 2,
    parameter int DEAD_FRAMES     = 60,
    parameter int GRACE_FRAMES    = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] player_x,
    input  logic [COORD_W-1:0] road_left,
    input  logic [COORD_W-1:0] road_right,
    output logic               dead,
    output logic               offroad,
    output logic [1:0]         state,
    output logic [7:0]         crash_count
);

    typedef enum logic [1:0] {
        S_ALIVE = 2'd0,
        S_DEAD  = 2'd1,
        S_GRACE = 2'd2
    } state_t;

    // One frame counter serves both DEAD and GRACE, so size it for the longer.
    localparam int FRM_MAX = (DEAD_FRAMES > GRACE_FRAMES) ? DEAD_FRAMES : GRACE_FRAMES;
    localparam int FRM_W   = $clog2(FRM_MAX + 1);
    localparam int DEB_W   = $clog2(DEBOUNCE_FRAMES + 1);

    // Counters compare against "last value" so the terminal tick is detected
    // on the same edge that would otherwise increment past the limit.
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_FRAMES - 1);
    localparam logic [FRM_W-1:0] DEAD_LAST = FRM_W'(DEAD_FRAMES - 1);
`ifdef CRASH_GRACE_EN
    localparam logic [FRM_W-1:0] GRACE_LAST = FRM_W'(GRACE_FRAMES - 1);
`endif

    state_t             state_q, state_d;
    logic [DEB_W-1:0]   deb_q, deb_d;
    logic [FRM_W-1:0]   frm_q, frm_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               offroad_q, offroad_d;
    logic               dead_q, dead_d;

    logic [COORD_W:0]   right_edge;
    logic               off_now;

    // Right edge is computed one bit wider so a sprite near the screen edge
    // cannot wrap around and look on-road. An inverted road is always off.
    assign right_edge = {1'b0, player_x} + (COORD_W + 1)'(PLAYER_W - 1);
    assign off_now    = (player_x < road_left)
                      | (right_edge > {1'b0, road_right})
                      | (road_left > road_right);

    // Next-state logic. Nothing moves except on a frame tick.
    always_comb begin
        state_d   = state_q;
        deb_d     = deb_q;
        frm_d     = frm_q;
        cnt_d     = cnt_q;
        offroad_d = offroad_q;

        if (frame_tick) begin
            offroad_d = off_now;
            case (state_q)
                S_ALIVE: begin
                    if (off_now) begin
                        if (deb_q == DEB_LAST) begin
                            state_d = S_DEAD;
                            deb_d   = '0;
                            frm_d   = '0;
                            if (cnt_q != 8'hFF) begin
                                cnt_d = cnt_q + 8'd1;
                            end
                        end else begin
                            deb_d = deb_q + DEB_W'(1);
                        end
                    end else begin
                        deb_d = '0;
                    end
                end
                S_DEAD: begin
                    if (frm_q == DEAD_LAST) begin
                        frm_d = '0;
`ifdef CRASH_GRACE_EN
                        state_d = S_GRACE;
`else
                        state_d = S_ALIVE;
`endif
                    end else begin
                        frm_d = frm_q + FRM_W'(1);
                    end
                end
`ifdef CRASH_GRACE_EN
                // Debounce is held at zero; the exit tick is not evaluated.
                S_GRACE: begin
                    deb_d = '0;
                    if (frm_q == GRACE_LAST) begin
                        frm_d   = '0;
                        state_d = S_ALIVE;
                    end else begin
                        frm_d = frm_q + FRM_W'(1);
                    end
                end
`endif
                default: begin
                    state_d = S_ALIVE;
                    deb_d   = '0;
                    frm_d   = '0;
                end
            endcase
        end

        dead_d = (state_d == S_DEAD);
    end

    // State and output registers; reset overrides any coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_ALIVE;
            deb_q     <= '0;
            frm_q     <= '0;
            cnt_q     <= '0;
            offroad_q <= 1'b0;
            dead_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            deb_q     <= deb_d;
            frm_q     <= frm_d;
            cnt_q     <= cnt_d;
            offroad_q <= offroad_d;
            dead_q    <= dead_d;
        end
    end

    assign dead        = dead_q;
    assign offroad     = offroad_q;
    assign state       = state_q;
    assign crash_count = cnt_q;

endmodule

// File: tb/tb_crash_detector.sv
// ---------------------------------------------------------------------------
// tb_crash_detector
//
// Directed bench for crash_detector: on-road idling, single off-road frames
// that must not trigger, a full crash / dead / (grace) / recrash sequence,
// an inverted road, counter saturation and reset in the middle of DEAD.
// Expected state after DEAD depends on CRASH_GRACE_EN.
// ---------------------------------------------------------------------------
module tb_crash_detector;

    localparam int COORD_W         = 10;
    localparam int PLAYER_W        = 16;
    localparam int DEBOUNCE_FRAMES = 2;
    localparam int DEAD_FRAMES     = 60;
    localparam int GRACE_FRAMES    = 30;

`ifdef CRASH_GRACE_EN
    localparam int GR_TICKS        = GRACE_FRAMES;
    localparam int AFTER_DEAD      = 2;
`else
    localparam int GR_TICKS        = 0;
    localparam int AFTER_DEAD      = 0;
`endif

    logic               clk;
    logic               rst;
    logic               frame_tick;
    logic [COORD_W-1:0] player_x;
    logic [COORD_W-1:0] road_left;
    logic [COORD_W-1:0] road_right;
    logic               dead;
    logic               offroad;
    logic [1:0]         state;
    logic [7:0]         crash_count;

    int checks = 0;
    int errors = 0;

    crash_detector #(
        .COORD_W         (COORD_W),
        .PLAYER_W        (PLAYER_W),
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
        .DEAD_FRAMES     (DEAD_FRAMES),
        .GRACE_FRAMES    (GRACE_FRAMES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .player_x    (player_x),
        .road_left   (road_left),
        .road_right  (road_right),
        .dead        (dead),
        .offroad     (offroad),
        .state       (state),
        .crash_count (crash_count)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One frame: tick for one cycle, then one idle cycle. Returns on the
    // falling edge after the tick was sampled, so outputs are settled.
    task automatic applyStimulus(input int px, input int rl, input int rr);
        @(negedge clk);
        player_x   = COORD_W'(px);
        road_left  = COORD_W'(rl);
        road_right = COORD_W'(rr);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input int e_dead, input int e_off,
                               input int e_state, input int e_cnt);
        checkValue({tag, ".dead"},        {31'd0, dead},        32'(e_dead));
        checkValue({tag, ".offroad"},     {31'd0, offroad},     32'(e_off));
        checkValue({tag, ".state"},       {30'd0, state},       32'(e_state));
        checkValue({tag, ".crash_count"}, {24'd0, crash_count}, 32'(e_cnt));
    endtask

    initial begin
        rst        = 1'b1;
        frame_tick = 1'b0;
        player_x   = 10'd150;
        road_left  = 10'd100;
        road_right = 10'd300;
        repeat (2) @(negedge clk);
        checkOutput("reset", 0, 0, 0, 0);
        rst = 1'b0;

        $display("[TB] on-road idling");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(150, 100, 300);
            checkOutput("onroad", 0, 0, 0, 0);
        end

        $display("[TB] single off-road frames past the right edge");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(290, 100, 300);
            checkOutput("edge_off", 0, 1, 0, 0);
            applyStimulus(150, 100, 300);
            checkOutput("edge_on", 0, 0, 0, 0);
        end

        $display("[TB] crash off the left edge");
        applyStimulus(50, 100, 300);
        checkOutput("crash_t1", 0, 1, 0, 0);
        applyStimulus(50, 100, 300);
        checkOutput("crash_t2", 1, 1, 1, 1);
        @(negedge clk);
        checkOutput("crash_idle", 1, 1, 1, 1);

        // Geometry is ignored in DEAD apart from offroad.
        for (int i = 0; i < DEAD_FRAMES - 1; i++) begin
            applyStimulus(150, 100, 300);
            checkOutput("dead_hold", 1, 0, 1, 1);
        end
        applyStimulus(50, 100, 300);
        checkOutput("dead_end", 0, 1, AFTER_DEAD, 1);

`ifdef CRASH_GRACE_EN
        $display("[TB] grace window while off-road");
        for (int i = 0; i < GRACE_FRAMES - 1; i++) begin
            applyStimulus(50, 100, 300);
            checkOutput("grace_hold", 0, 1, 2, 1);
        end
        applyStimulus(50, 100, 300);
        checkOutput("grace_end", 0, 1, 0, 1);
`endif

        $display("[TB] recrash after returning to ALIVE");
        applyStimulus(50, 100, 300);
        checkOutput("recrash_t1", 0, 1, 0, 1);
        applyStimulus(50, 100, 300);
        checkOutput("recrash_t2", 1, 1, 1, 2);

        repeat (DEAD_FRAMES + GR_TICKS) applyStimulus(50, 100, 300);
        applyStimulus(150, 100, 300);
        checkOutput("realign", 0, 0, 0, 2);

        $display("[TB] inverted road");
        applyStimulus(350, 400, 300);
        checkOutput("inv_t1", 0, 1, 0, 2);
        applyStimulus(350, 400, 300);
        checkOutput("inv_t2", 1, 1, 1, 3);

        $display("[TB] forcing crashes up to saturation");
        for (int n = 4; n <= 300; n++) begin
            repeat (DEAD_FRAMES + GR_TICKS) applyStimulus(50, 100, 300);
            applyStimulus(50, 100, 300);
            applyStimulus(50, 100, 300);
            checkOutput("sat_crash", 1, 1, 1, (n > 255) ? 255 : n);
        end

        $display("[TB] reset in the middle of DEAD with a coincident tick");
        repeat (5) applyStimulus(50, 100, 300);
        checkOutput("pre_rst", 1, 1, 1, 255);
        @(negedge clk);
        rst        = 1'b1;
        frame_tick = 1'b1;
        player_x   = 10'd50;
        @(negedge clk);
        rst        = 1'b0;
        frame_tick = 1'b0;
        checkOutput("rst_mid_dead", 0, 0, 0, 0);
        applyStimulus(150, 100, 300);
        checkOutput("post_rst_on", 0, 0, 0, 0);
        applyStimulus(50, 100, 300);
        checkOutput("post_rst_off", 0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
